// File: rtl/color_core_dispatcher.sv
// Round-robin task dispatcher for N HLS color cores with a finish-record stream.
// Optional statistics counters: define COLOR_DISPATCH_STATS_EN.
module color_core_dispatcher #(
    parameter int N_CORES  = 4,
    parameter int TQ_WIDTH = 128,
    parameter int TS_WIDTH = 32,
    parameter int CID_W    = $clog2(N_CORES)
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    input  logic                        s_task_valid,
    output logic                        s_task_ready,
    input  logic [TQ_WIDTH-1:0]         s_task_data,
    output logic [N_CORES-1:0]          core_ap_start,
    input  logic [N_CORES-1:0]          core_ap_ready,
    input  logic [N_CORES-1:0]          core_ap_done,
    input  logic [N_CORES-1:0]          core_ap_idle,
    output logic [N_CORES*TQ_WIDTH-1:0] core_task_in,
    output logic                        fin_valid,
    input  logic                        fin_ready,
    output logic [CID_W-1:0]            fin_core,
    output logic [TS_WIDTH-1:0]         fin_ts,
    output logic [CID_W:0]              busy_count,
    output logic [31:0]                 stat_dispatched,
    output logic [31:0]                 stat_stall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } slot_e;

    slot_e               state_q [N_CORES];
    slot_e               state_d [N_CORES];
    logic [TQ_WIDTH-1:0] task_q  [N_CORES];
    logic [TQ_WIDTH-1:0] task_d  [N_CORES];
    logic [CID_W-1:0]    rr_q, rr_d;
    logic [CID_W-1:0]    sel, fin_sel;
    logic                any_idle, fin_any;
    logic                accept, pop;
    logic                unused_idle;

    assign unused_idle = ^core_ap_idle;

    // Descending scans so the lowest offset / lowest index wins.
    always_comb begin
        int idx;
        sel      = '0;
        any_idle = 1'b0;
        fin_sel  = '0;
        fin_any  = 1'b0;
        for (int i = N_CORES - 1; i >= 0; i--) begin
            idx = (int'(rr_q) + i) % N_CORES;
            if (state_q[idx] == S_IDLE) begin
                sel      = CID_W'(idx);
                any_idle = 1'b1;
            end
            if (state_q[i] == S_DONE) begin
                fin_sel = CID_W'(i);
                fin_any = 1'b1;
            end
        end
    end

    assign s_task_ready = !ap_rst && any_idle;
    assign accept       = s_task_valid && s_task_ready;
    assign pop          = fin_any && fin_ready;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rr_q <= '0;
            for (int c = 0; c < N_CORES; c++) state_q[c] <= S_IDLE;
        end else begin
            rr_q <= rr_d;
            for (int c = 0; c < N_CORES; c++) state_q[c] <= state_d[c];
        end
    end

    always_ff @(posedge ap_clk) begin
        for (int c = 0; c < N_CORES; c++) task_q[c] <= task_d[c];
    end

    always_comb begin
        rr_d = rr_q;
        if (accept) rr_d = CID_W'((int'(sel) + 1) % N_CORES);
        for (int c = 0; c < N_CORES; c++) begin
            state_d[c] = state_q[c];
            task_d[c]  = task_q[c];
            unique case (state_q[c])
                S_IDLE: begin
                    if (accept && sel == CID_W'(c)) begin
                        state_d[c] = S_START;
                        task_d[c]  = s_task_data;
                    end
                end
                S_START: if (core_ap_ready[c]) state_d[c] = S_RUN;
                S_RUN:   if (core_ap_done[c])  state_d[c] = S_DONE;
                S_DONE:  if (pop && fin_sel == CID_W'(c)) state_d[c] = S_IDLE;
                default: state_d[c] = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_count = '0;
        for (int c = 0; c < N_CORES; c++) begin
            core_ap_start[c] = (state_q[c] == S_START);
            core_task_in[c*TQ_WIDTH +: TQ_WIDTH] = task_q[c];
            if (state_q[c] != S_IDLE) busy_count = busy_count + (CID_W+1)'(1);
        end
        fin_valid = fin_any;
        fin_core  = fin_sel;
        fin_ts    = task_q[fin_sel][TS_WIDTH-1:0];
    end

`ifdef COLOR_DISPATCH_STATS_EN
    logic [31:0] disp_q, disp_d, stall_q, stall_d;

    always_comb begin
        disp_d  = disp_q;
        stall_d = stall_q;
        if (accept) disp_d = disp_q + 32'd1;
        if (s_task_valid && !s_task_ready) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            disp_q  <= '0;
            stall_q <= '0;
        end else begin
            disp_q  <= disp_d;
            stall_q <= stall_d;
        end
    end

    assign stat_dispatched = disp_q;
    assign stat_stall      = stall_q;
`else
    assign stat_dispatched = '0;
    assign stat_stall      = '0;
`endif

endmodule

// File: doc/color_core_dispatcher.md
Name: color_core_dispatcher

Overview:
- Scheduler sitting between a tile's task-queue dequeue stream and N HLS-style color task cores.
- Each core uses the ap_start/ap_ready/ap_done/ap_idle handshake with a task_in word.
- Accepts one task per cycle, assigns it round-robin to an idle core, and holds task_in stable for the whole task.
- Collects the single-cycle ap_done pulses into a backpressured finish stream that reports core id and timestamp to the commit logic.

Parameters:
N_CORES, 4, number of cores managed (2..16)
TQ_WIDTH, 128, task word width; layout {args, ttype, object, ts}, ts in the low bits
TS_WIDTH, 32, timestamp width (low TS_WIDTH bits of the task word)
CID_W, $clog2(N_CORES), core id width

Ports:
ap_clk  in  1  clock
ap_rst  in  1  synchronous active-high reset
s_task_valid  in  1  incoming task valid
s_task_ready  out  1  dispatcher can accept a task
s_task_data  in  TQ_WIDTH  incoming task word
core_ap_start  out  N_CORES  per-core start
core_ap_ready  in  N_CORES  per-core ready (start accepted when start&ready)
core_ap_done  in  N_CORES  per-core single-cycle done pulse
core_ap_idle  in  N_CORES  per-core idle (status only)
core_task_in  out  N_CORES*TQ_WIDTH  per-core task word, core c at slice [c*TQ_WIDTH +: TQ_WIDTH]
fin_valid  out  1  finish record valid
fin_ready  in  1  finish record accepted
fin_core  out  CID_W  core that finished
fin_ts  out  TS_WIDTH  timestamp of finished task
busy_count  out  CID_W+1  number of non-IDLE cores
stat_dispatched  out  32  tasks dispatched (see Optional Feature)
stat_stall  out  32  input stall cycles (see Optional Feature)

Behaviour:
- One clock; synchronous active-high reset ap_rst.
- Reset values:
  - all per-core slots IDLE; rr_ptr=0; task registers don't-care.
  - core_ap_start=0, fin_valid=0, busy_count=0, stats=0.
  - s_task_ready=0 while ap_rst=1.
- Per-core slot FSM (2 bits), states IDLE -> STARTING -> RUNNING -> DONE_PENDING -> IDLE.
- IDLE:
  - Selectable. Selected core = first IDLE index scanning rr_ptr, rr_ptr+1, ... mod N_CORES.
  - s_task_ready = (!ap_rst) & (any IDLE), combinational from slot state only.
  - On s_task_valid & s_task_ready: latch s_task_data into task_reg[sel]; slot -> STARTING; rr_ptr <= (sel+1) mod N_CORES.
- STARTING:
  - core_ap_start[c]=1 (decoded from registered state; first assertion is the cycle after acceptance).
  - On core_ap_ready[c]: -> RUNNING next cycle; start drops.
  - Start held indefinitely while ready=0.
- RUNNING:
  - core_ap_start[c]=0.
  - On core_ap_done[c]: -> DONE_PENDING.
  - ap_done seen in IDLE or STARTING is ignored.
- DONE_PENDING:
  - Candidate for finish output.
  - fin_valid = any DONE_PENDING; fin_core = lowest DONE_PENDING index (fixed priority).
  - fin_ts = task_reg[fin_core][TS_WIDTH-1:0].
  - On fin_valid & fin_ready: that slot -> IDLE. It is selectable from the following cycle; never reused in the same cycle it frees.
- core_task_in[c] = task_reg[c] unconditionally; stable from STARTING until the slot returns to IDLE.
- Finish data stays stable while fin_valid=1 & fin_ready=0, unless a lower-index core enters DONE_PENDING (re-prioritisation is allowed; every record is eventually emitted exactly once).
- Simultaneous events are independent: acceptance on one core, start handshake on another, done on a third, and finish pop on a fourth can all occur in one cycle.
- busy_count = popcount of non-IDLE slots, combinational.
- Mid-operation reset: all slots forced IDLE next edge, pending finishes discarded, core_ap_start deasserted in the cycle after reset is sampled. Cores are expected to be reset by the same signal.
- No overflow is possible: at most one finish record per core exists.

Optional Feature:
- Macro: COLOR_DISPATCH_STATS_EN.
- Defined:
  - stat_dispatched increments on each s_task_valid & s_task_ready.
  - stat_stall increments on each cycle with s_task_valid & !s_task_ready.
  - Both are 32-bit, wrap at 2^32, and clear on ap_rst.
- Not defined: both ports tied to 0 and no counter flops are instantiated. Port list is identical in both builds.

Test Plan:
- Reset; task ts=0x10 at cycle T; core0 ready=1 -> core_ap_start[0]=1 at T+1 only; done pulse at T+5 -> fin_valid=1, fin_core=0, fin_ts=0x10 at T+6; pop -> busy_count=0.
- Five back-to-back tasks ts=1..5; cores ack, no done -> cores 0,1,2,3 receive ts 1..4; s_task_ready=0; busy_count=4; 5th held; after core2 done+pop, 5th goes to core2 one cycle later.
- Round robin: after core0 finishes, rr_ptr=1 with core1 busy and others idle -> next task goes to core2.
- Simultaneous done on cores 3 and 1, fin_ready=1 -> fin_core=1 then fin_core=3 on consecutive cycles, with the correct ts each.
- fin_ready=0 for 10 cycles with core0 DONE_PENDING -> fin_valid held, fin_ts stable, core0 not redispatched; s_task_ready reflects the remaining idle cores only.
- Reset asserted while 3 cores RUNNING and 1 DONE_PENDING -> next cycle all start=0, fin_valid=0, busy_count=0; with COLOR_DISPATCH_STATS_EN defined, stat_dispatched=0 and stat_stall=0.
